serial_chan_arbiter: RTL and testbench
======================================

# serial_chan_arbiter

Shares the single 32-bit bramfeeder message channel of the serial physical device between `N_CHAN` client channels. It sits between the serial device's bramfeeder put/get pins and the client-side channel endpoints. Outbound, it round-robin arbitrates between requesters and frames each message with a header word. Inbound, it parses header words from the processor side and routes payload words to the addressed channel, discarding malformed traffic.

## Interface
Parameters:
- `N_CHAN`, 4: number of client channels, 2..16.
- `LEN_W`, 16: message length field width in words; fixed by header format.

Ports:
- `serial_clk_pin` in 1: the only clock.
- `serial_rst_pin` in 1: reset, asynchronous, active-low.
- `tx_req` in N_CHAN: per-channel message request.
- `tx_len` in N_CHAN*16: per-channel payload length in words, valid with `tx_req`.
- `tx_gnt` out N_CHAN: one-cycle grant pulse.
- `tx_data` in N_CHAN*32: per-channel payload word.
- `tx_valid` in N_CHAN: payload word valid.
- `tx_ready` out N_CHAN: payload word accepted.
- `rx_data` out 32: inbound payload word, broadcast to all channels.
- `rx_valid` out N_CHAN: one-hot; word valid for that channel.
- `rx_ready` in N_CHAN: channel accepts a word.
- `put_rdy` in 1: bramfeeder `RDY_ppcMessageInput_put`.
- `put_en` out 1: bramfeeder `EN_ppcMessageInput_put`.
- `put_data` out 32: bramfeeder `ppcMessageInput_put`.
- `get_rdy` in 1: bramfeeder `RDY_ppcMessageOutput_get`.
- `get_en` out 1: bramfeeder `EN_ppcMessageOutput_get`.
- `get_data` in 32: bramfeeder `ppcMessageOutput_get`.
- `stat_drop` out 16: count of discarded inbound words.
- `stat_msgs` out 16: count of outbound messages sent.

## Operation
- Header word format: `[31:24]`=8'hA5 sync byte, `[23:16]`=channel id, `[15:0]`=payload length. A length of 0 is legal and means header only.
- TX FSM has three states: T_IDLE, T_HDR, T_BODY.
  - T_IDLE: if any `tx_req` is set, grant the first requester at or after `rr_ptr`. Register the channel and `tx_len`, pulse `tx_gnt`, then go to T_HDR.
  - T_HDR: `put_data` carries the header and `put_en = put_rdy`. When the header is accepted, go to T_BODY if len>0; otherwise go to T_IDLE.
  - T_BODY: `put_data = tx_data[gnt]`, `put_en = put_rdy & tx_valid[gnt]`, `tx_ready[gnt] = put_rdy`. Each accepted word decrements the counter. After the last word, go to T_IDLE.
  - On return to T_IDLE, `rr_ptr` becomes gnt+1, wrapping modulo N_CHAN, and `stat_msgs` increments.
- RX FSM has three states: R_HDR, R_BODY, R_DROP. `get_en` is only ever asserted when `get_rdy` is high.
  - R_HDR: `get_en = get_rdy`.
    - Bad sync byte: discard the word, increment `stat_drop`, stay in R_HDR.
    - Channel id ≥ N_CHAN with len>0: go to R_DROP.
    - Valid channel with len>0: go to R_BODY.
    - len=0: stay in R_HDR.
  - R_BODY: `rx_data = get_data`, `rx_valid[ch] = get_rdy`, `get_en = get_rdy & rx_ready[ch]`. Decrement per word; after the last word, go to R_HDR.
  - R_DROP: `get_en = get_rdy`. Each word increments `stat_drop`; after the last word, go to R_HDR.
- TX and RX are fully independent and may both transfer in the same cycle.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - TX in T_IDLE, RX in R_HDR, `rr_ptr`=0, both stats 0.
  - `put_en`, `get_en`, `tx_gnt`, `tx_ready`, `rx_valid` all 0.
  - `put_data` and `rx_data` are 0 when not enabled.
- Reset is asynchronous. Asserting it mid-message aborts the message with no flush: the partial frame is lost, and clients must reissue.
- Outbound latency: `tx_req` is sampled at edge N, `tx_gnt` is high during cycle N+1, and the header is presented in cycle N+1. The earliest first payload word is in cycle N+2.
- Back-to-back messages: the next grant happens one cycle after the last word (one T_IDLE cycle).
- Combinational paths:
  - `put_en`/`get_en` follow `put_rdy`/`get_rdy` in the same cycle.
  - `rx_valid`/`tx_ready` are combinational from the bramfeeder RDY signals and the current state only.
- A requester must hold `tx_req` until `tx_gnt` and deassert it in the cycle after. A request still high in T_IDLE after its own message is eligible again, but only at its round-robin turn.

## Configuration
- `SERIAL_ARB_STATS_EN`:
  - Defined: the `stat_drop` and `stat_msgs` counters are implemented.
  - Undefined: both ports are tied to 0 and no counter flops exist. Dropping behaviour is unchanged.

## Structure
- Package `serial_arb_pkg` holds:
  - `HDR_SYNC`=8'hA5 and the header field bit positions;
  - the enum types `tx_state_t` and `rx_state_t`;
  - the function `make_hdr(ch, len)`.
- Sub-module `serial_rr_arb` is a combinational round-robin pick that takes `req` and `ptr` and returns a one-hot grant plus a valid flag. It is instantiated once.

## Test plan
- N_CHAN=4, `put_rdy`=1. ch2 requests len=3 with data 0x11, 0x22, 0x33. Expect put words 0xA5020003, 0x11, 0x22, 0x33, then `stat_msgs`=1.
- ch0 and ch3 request len=1 simultaneously with `rr_ptr`=0. Expect ch0's header first. Then `rr_ptr`=1, so ch3 is served next with no idle beyond one cycle.
- Inbound 0xA5010002, 0xDEAD, 0xBEEF with `rx_ready[1]` low for 3 cycles. Expect `get_en` to stay low until ready. `rx_valid`=4'b0010 carries both words in order.
- Inbound 0xA5090002 plus two words (channel out of range). Expect both payload words consumed, `stat_drop`=2, and no `rx_valid`.
- Inbound 0x12345678 (bad sync), then 0xA5000000. Expect `stat_drop`=1, the zero-length header accepted, and RX in R_HDR.
- Assert `serial_rst_pin` low mid-T_BODY with 2 words remaining. Expect `put_en`=0 immediately and the FSM back in T_IDLE. A new request after release produces a fresh header.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// Shared definitions for serial_chan_arbiter: header word layout,
// TX/RX state encodings and the header builder.
package serial_arb_pkg;

  // Header word layout: {sync[7:0], channel id[7:0], length[15:0]}
  localparam logic [7:0] HDR_SYNC     = 8'hA5;
  localparam int         HDR_SYNC_LSB = 24;
  localparam int         HDR_SYNC_W   = 8;
  localparam int         HDR_CH_LSB   = 16;
  localparam int         HDR_CH_W     = 8;
  localparam int         HDR_LEN_LSB  = 0;
  localparam int         HDR_LEN_W    = 16;
  localparam int         WORD_W       = 32;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HDR  = 2'd1,
    T_BODY = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    R_HDR  = 2'd0,
    R_BODY = 2'd1,
    R_DROP = 2'd2
  } rx_state_t;

  // Build an outbound header word for channel ch carrying len payload words.
  function automatic logic [WORD_W-1:0] make_hdr(input logic [HDR_CH_W-1:0]  ch,
                                                 input logic [HDR_LEN_W-1:0] len);
    make_hdr = {HDR_SYNC, ch, len};
  endfunction

endpackage

// File: rtl/serial_rr_arb.sv
// Combinational round-robin pick: grants the first requester at or after
// ptr, wrapping modulo N. Works for any N, not only powers of two.
module serial_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0]   rot_req;
  logic [N-1:0]   pick;
  logic [2*N-1:0] gnt_dbl;

  // Rotate requests so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    pick    = '0;
    valid   = 1'b0;
    rot_req = N'({req, req} >> ptr);
    for (int i = 0; i < N; i++) begin
      if (!valid && rot_req[i]) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
    gnt_dbl = {{N{1'b0}}, pick} << ptr;
    gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/serial_chan_arbiter.sv
// Shares the serial device's 32-bit bramfeeder message channel between
// N_CHAN clients. Outbound: round-robin arbitration and header framing.
// Inbound: header parsing, routing to the addressed channel, and discard
// of bad-sync words and traffic for channels that do not exist.
// Optional statistics counters are built when SERIAL_ARB_STATS_EN is defined;
// otherwise stat_drop/stat_msgs read as zero and no counter flops exist.
module serial_chan_arbiter
  import serial_arb_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int LEN_W  = 16
) (
  input  logic                  serial_clk_pin,
  input  logic                  serial_rst_pin,
  // client transmit side
  input  logic [N_CHAN-1:0]       tx_req,
  input  logic [N_CHAN*LEN_W-1:0] tx_len,
  output logic [N_CHAN-1:0]       tx_gnt,
  input  logic [N_CHAN*32-1:0]    tx_data,
  input  logic [N_CHAN-1:0]       tx_valid,
  output logic [N_CHAN-1:0]       tx_ready,
  // client receive side
  output logic [31:0]             rx_data,
  output logic [N_CHAN-1:0]       rx_valid,
  input  logic [N_CHAN-1:0]       rx_ready,
  // bramfeeder put (outbound)
  input  logic                    put_rdy,
  output logic                    put_en,
  output logic [31:0]             put_data,
  // bramfeeder get (inbound)
  input  logic                    get_rdy,
  output logic                    get_en,
  input  logic [31:0]             get_data,
  // statistics
  output logic [15:0]             stat_drop,
  output logic [15:0]             stat_msgs
);

  localparam int              PTR_W     = $clog2(N_CHAN);
  localparam logic [7:0]      N_CHAN_ID = 8'(N_CHAN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  tx_state_t                tx_state_q;
  logic [N_CHAN-1:0]        gnt_oh_q;
  logic [PTR_W-1:0]         gnt_idx_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [LEN_W-1:0]         tx_cnt_q;
  logic                     gnt_pulse_q;

  logic [N_CHAN-1:0]        arb_gnt;
  logic                     arb_valid;
  logic [PTR_W-1:0]         arb_idx;
  logic [LEN_W-1:0]         arb_len;
  logic [31:0]              sel_data;
  logic                     sel_valid;
  logic                     tx_done;

  serial_rr_arb #(
    .N     (N_CHAN),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req   (tx_req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // Encode the arbiter's one-hot pick and fetch that client's length.
  always_comb begin
    arb_idx = '0;
    arb_len = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = PTR_W'(i);
        arb_len = tx_len[i*LEN_W +: LEN_W];
      end
    end
  end

  // Route the granted client's payload word onto the put port.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (gnt_oh_q[i]) sel_data = tx_data[i*32 +: 32];
    end
    sel_valid = |(tx_valid & gnt_oh_q);
  end

  // Put-side handshake; combinational from put_rdy and the TX state only.
  always_comb begin
    put_en   = 1'b0;
    put_data = '0;
    tx_ready = '0;
    tx_done  = 1'b0;
    case (tx_state_q)
      T_HDR: begin
        put_en   = put_rdy;
        put_data = put_rdy ? make_hdr(8'(gnt_idx_q), tx_cnt_q) : '0;
        tx_done  = put_rdy && (tx_cnt_q == '0);
      end
      T_BODY: begin
        put_en   = put_rdy & sel_valid;
        put_data = (put_rdy & sel_valid) ? sel_data : '0;
        tx_ready = gnt_oh_q & {N_CHAN{put_rdy}};
        tx_done  = put_rdy && sel_valid && (tx_cnt_q == LEN_ONE);
      end
      default: ;
    endcase
  end

  // The grant is a one-cycle pulse in the first T_HDR cycle.
  assign tx_gnt = gnt_pulse_q ? gnt_oh_q : '0;

  // TX FSM: arbitrate in T_IDLE, send header, stream payload, advance rr_ptr.
  always_ff @(posedge serial_clk_pin or negedge serial_rst_pin) begin
    // NOTE: async active-low reset in the sensitivity list; an abort mid-frame drops the frame.
    if (!serial_rst_pin) begin
      tx_state_q  <= T_IDLE;
      gnt_oh_q    <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      tx_cnt_q    <= '0;
      gnt_pulse_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      gnt_pulse_q <= 1'b0;
      case (tx_state_q)
        T_IDLE: begin
          if (arb_valid) begin
            gnt_oh_q    <= arb_gnt;
            gnt_idx_q   <= arb_idx;
            tx_cnt_q    <= arb_len;
            gnt_pulse_q <= 1'b1;
            tx_state_q  <= T_HDR;
          end
        end
        T_HDR: begin
          if (put_rdy) tx_state_q <= (tx_cnt_q == '0) ? T_IDLE : T_BODY;
        end
        T_BODY: begin
          if (put_en) begin
            tx_cnt_q <= tx_cnt_q - LEN_ONE;
            if (tx_cnt_q == LEN_ONE) tx_state_q <= T_IDLE;
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
      if (tx_done) begin
        rr_ptr_q <= (gnt_idx_q == PTR_W'(N_CHAN - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  rx_state_t                rx_state_q;
  logic [N_CHAN-1:0]        rx_oh_q;
  logic [LEN_W-1:0]         rx_cnt_q;

  logic [HDR_SYNC_W-1:0]    hdr_sync;
  logic [HDR_CH_W-1:0]      hdr_ch;
  logic [LEN_W-1:0]         hdr_len;
  logic                     hdr_sync_ok;
  logic                     hdr_ch_ok;
  logic [N_CHAN-1:0]        hdr_oh;
  logic                     rx_sel_ready;

  // Split the incoming word into header fields and decode the channel.
  always_comb begin
    hdr_sync    = get_data[HDR_SYNC_LSB +: HDR_SYNC_W];
    hdr_ch      = get_data[HDR_CH_LSB +: HDR_CH_W];
    hdr_len     = get_data[HDR_LEN_LSB +: LEN_W];
    hdr_sync_ok = (hdr_sync == HDR_SYNC);
    hdr_ch_ok   = (hdr_ch < N_CHAN_ID);
    hdr_oh      = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      hdr_oh[i] = (hdr_ch == 8'(i));
    end
    rx_sel_ready = |(rx_ready & rx_oh_q);
  end

  // Get-side handshake; get_en never rises without get_rdy.
  always_comb begin
    get_en   = 1'b0;
    rx_valid = '0;
    rx_data  = '0;
    case (rx_state_q)
      R_HDR:  get_en = get_rdy;
      R_DROP: get_en = get_rdy;
      R_BODY: begin
        rx_valid = rx_oh_q & {N_CHAN{get_rdy}};
        rx_data  = get_rdy ? get_data : '0;
        get_en   = get_rdy & rx_sel_ready;
      end
      default: ;
    endcase
  end

  // RX FSM: parse headers, deliver payload or drain it for unknown channels.
  always_ff @(posedge serial_clk_pin or negedge serial_rst_pin) begin
    if (!serial_rst_pin) begin
      rx_state_q <= R_HDR;
      rx_oh_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      case (rx_state_q)
        R_HDR: begin
          if (get_en && hdr_sync_ok && (hdr_len != '0)) begin
            rx_cnt_q <= hdr_len;
            if (hdr_ch_ok) begin
              rx_oh_q    <= hdr_oh;
              rx_state_q <= R_BODY;
            end else begin
              rx_state_q <= R_DROP;
            end
          end
        end
        R_BODY, R_DROP: begin
          if (get_en) begin
            rx_cnt_q <= rx_cnt_q - LEN_ONE;
            if (rx_cnt_q == LEN_ONE) rx_state_q <= R_HDR;
          end
        end
        default: rx_state_q <= R_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef SERIAL_ARB_STATS_EN
  logic [15:0] stat_drop_q, stat_drop_d;
  logic [15:0] stat_msgs_q, stat_msgs_d;
  logic        drop_inc;

  // Saturating increments for dropped inbound words and completed messages.
  always_comb begin
    drop_inc    = get_en && (((rx_state_q == R_HDR) && !hdr_sync_ok) ||
                             (rx_state_q == R_DROP));
    stat_drop_d = stat_drop_q;
    stat_msgs_d = stat_msgs_q;
    if (drop_inc && (stat_drop_q != 16'hFFFF)) stat_drop_d = stat_drop_q + 16'd1;
    if (tx_done  && (stat_msgs_q != 16'hFFFF)) stat_msgs_d = stat_msgs_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge serial_clk_pin or negedge serial_rst_pin) begin
    if (!serial_rst_pin) begin
      stat_drop_q <= '0;
      stat_msgs_q <= '0;
    end else begin
      stat_drop_q <= stat_drop_d;
      stat_msgs_q <= stat_msgs_d;
    end
  end

  assign stat_drop = stat_drop_q;
  assign stat_msgs = stat_msgs_q;
`else
  assign stat_drop = '0;
  assign stat_msgs = '0;
`endif

endmodule

// File: tb/tb_serial_chan_arbiter.sv
// Self-checking bench for serial_chan_arbiter (N_CHAN=4): a per-cycle TX
// vector table plus hand-written RX and reset-abort sequences.
module tb_serial_chan_arbiter;

  localparam int N = 4;
`ifdef SERIAL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      tx_req;
  logic [N*16-1:0]   tx_len;
  logic [N-1:0]      tx_gnt;
  logic [N*32-1:0]   tx_data;
  logic [N-1:0]      tx_valid;
  logic [N-1:0]      tx_ready;
  logic [31:0]       rx_data;
  logic [N-1:0]      rx_valid;
  logic [N-1:0]      rx_ready;
  logic              put_rdy;
  logic              put_en;
  logic [31:0]       put_data;
  logic              get_rdy;
  logic              get_en;
  logic [31:0]       get_data;
  logic [15:0]       stat_drop;
  logic [15:0]       stat_msgs;

  always #5 clk = ~clk;

  serial_chan_arbiter #(.N_CHAN(N), .LEN_W(16)) dut (
    .serial_clk_pin (clk),
    .serial_rst_pin (rst_n),
    .tx_req         (tx_req),
    .tx_len         (tx_len),
    .tx_gnt         (tx_gnt),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .put_rdy        (put_rdy),
    .put_en         (put_en),
    .put_data       (put_data),
    .get_rdy        (get_rdy),
    .get_en         (get_en),
    .get_data       (get_data),
    .stat_drop      (stat_drop),
    .stat_msgs      (stat_msgs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected statistic value depends on whether the counters are built.
  function automatic logic [15:0] st(input logic [15:0] v);
    return STATS ? v : 16'd0;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [31:0] word;
    logic [3:0]  valid;
    logic        prdy;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rdy;
    logic [15:0] exp_msgs;
  } tx_vec_t;

  tx_vec_t tx_tab[14];

  // One RX cycle: drive, sample at the falling edge, advance past the next rising edge.
  task automatic rx_cycle(input string tag, input logic [31:0] d, input logic grdy,
                          input logic [3:0] rrdy, input logic exp_en,
                          input logic [3:0] exp_valid, input logic [31:0] exp_rdata);
    get_data = d;
    get_rdy  = grdy;
    rx_ready = rrdy;
    @(negedge clk);
    check({tag, "_get_en"},   32'(get_en),   32'(exp_en));
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'(exp_valid));
    check({tag, "_rx_data"},  rx_data,       exp_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ch0+ch3 contend from rr_ptr=0, then ch2 sends 3 words with a put stall and a valid gap.
    tx_tab[0]  = '{4'b1001, 16'd1, 32'h0,  4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 16'd0};
    tx_tab[1]  = '{4'b1001, 16'd1, 32'h0,  4'b1111, 1'b1, 1'b1, 32'hA5000001, 4'b0001, 4'b0000, 16'd0};
    tx_tab[2]  = '{4'b1000, 16'd1, 32'hC0, 4'b1111, 1'b1, 1'b1, 32'h000000C0, 4'b0000, 4'b0001, 16'd0};
    tx_tab[3]  = '{4'b1000, 16'd1, 32'h0,  4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 16'd1};
    tx_tab[4]  = '{4'b1000, 16'd1, 32'h0,  4'b1111, 1'b1, 1'b1, 32'hA5030001, 4'b1000, 4'b0000, 16'd1};
    tx_tab[5]  = '{4'b0000, 16'd1, 32'hC3, 4'b1111, 1'b1, 1'b1, 32'h000000C3, 4'b0000, 4'b1000, 16'd1};
    tx_tab[6]  = '{4'b0100, 16'd3, 32'h0,  4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 16'd2};
    tx_tab[7]  = '{4'b0100, 16'd3, 32'h0,  4'b1111, 1'b0, 1'b0, 32'h0,        4'b0100, 4'b0000, 16'd2};
    tx_tab[8]  = '{4'b0000, 16'd3, 32'h0,  4'b1111, 1'b1, 1'b1, 32'hA5020003, 4'b0000, 4'b0000, 16'd2};
    tx_tab[9]  = '{4'b0000, 16'd3, 32'h11, 4'b1111, 1'b1, 1'b1, 32'h00000011, 4'b0000, 4'b0100, 16'd2};
    tx_tab[10] = '{4'b0000, 16'd3, 32'h22, 4'b0000, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0100, 16'd2};
    tx_tab[11] = '{4'b0000, 16'd3, 32'h22, 4'b1111, 1'b1, 1'b1, 32'h00000022, 4'b0000, 4'b0100, 16'd2};
    tx_tab[12] = '{4'b0000, 16'd3, 32'h33, 4'b1111, 1'b1, 1'b1, 32'h00000033, 4'b0000, 4'b0100, 16'd2};
    tx_tab[13] = '{4'b0000, 16'd3, 32'h0,  4'b1111, 1'b1, 1'b0, 32'h0,        4'b0000, 4'b0000, 16'd3};

    tx_req = '0; tx_len = '0; tx_data = '0; tx_valid = '0;
    rx_ready = '0; put_rdy = 1'b0; get_rdy = 1'b0; get_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_put_en",    32'(put_en),    32'd0);
    check("rst_get_en",    32'(get_en),    32'd0);
    check("rst_tx_gnt",    32'(tx_gnt),    32'd0);
    check("rst_tx_ready",  32'(tx_ready),  32'd0);
    check("rst_rx_valid",  32'(rx_valid),  32'd0);
    check("rst_put_data",  put_data,       32'd0);
    check("rst_rx_data",   rx_data,        32'd0);
    check("rst_stat_drop", 32'(stat_drop), 32'd0);
    check("rst_stat_msgs", 32'(stat_msgs), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // TX vector table
    for (int i = 0; i < 14; i++) begin
      tx_req   = tx_tab[i].req;
      tx_len   = {N{tx_tab[i].len}};
      tx_data  = {N{tx_tab[i].word}};
      tx_valid = tx_tab[i].valid;
      put_rdy  = tx_tab[i].prdy;
      @(negedge clk);
      check($sformatf("tx%0d_put_en", i),   32'(put_en),    32'(tx_tab[i].exp_en));
      check($sformatf("tx%0d_put_data", i), put_data,       tx_tab[i].exp_data);
      check($sformatf("tx%0d_tx_gnt", i),   32'(tx_gnt),    32'(tx_tab[i].exp_gnt));
      check($sformatf("tx%0d_tx_ready", i), 32'(tx_ready),  32'(tx_tab[i].exp_rdy));
      check($sformatf("tx%0d_stat_msgs", i), 32'(stat_msgs), 32'(st(tx_tab[i].exp_msgs)));
      @(posedge clk);
      #1;
    end
    tx_valid = '0;

    // RX: ch1 message with the client stalling for three cycles
    rx_cycle("rx_hdr_ch1",  32'hA5010002, 1'b1, 4'b0000, 1'b1, 4'b0000, 32'h0);
    rx_cycle("rx_stall0",   32'h0000DEAD, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h0000DEAD);
    rx_cycle("rx_stall1",   32'h0000DEAD, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h0000DEAD);
    rx_cycle("rx_stall2",   32'h0000DEAD, 1'b1, 4'b0000, 1'b0, 4'b0010, 32'h0000DEAD);
    rx_cycle("rx_w0",       32'h0000DEAD, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000DEAD);
    rx_cycle("rx_w1",       32'h0000BEEF, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000BEEF);
    rx_cycle("rx_idle0",    32'h0,        1'b0, 4'b1111, 1'b0, 4'b0000, 32'h0);
    check("rx_drop_after_ch1", 32'(stat_drop), 32'(st(16'd0)));

    // RX: out-of-range channel, payload drained
    rx_cycle("rx_hdr_ch9",  32'hA5090002, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    rx_cycle("rx_drop0",    32'h00000001, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    rx_cycle("rx_drop1",    32'h00000002, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    check("rx_drop_ch9", 32'(stat_drop), 32'(st(16'd2)));

    // RX: bad sync word, then a zero-length header; RX must still be parsing headers
    rx_cycle("rx_badsync",  32'h12345678, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    check("rx_drop_badsync", 32'(stat_drop), 32'(st(16'd3)));
    rx_cycle("rx_hdr_len0", 32'hA5000000, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    rx_cycle("rx_hdr_ch1b", 32'hA5010001, 1'b1, 4'b1111, 1'b1, 4'b0000, 32'h0);
    rx_cycle("rx_w_ch1b",   32'h00000077, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h00000077);
    rx_cycle("rx_idle1",    32'h0,        1'b0, 4'b1111, 1'b0, 4'b0000, 32'h0);
    check("rx_drop_final", 32'(stat_drop), 32'(st(16'd3)));

    // Reset mid-body with two words left, then a fresh message
    tx_req   = 4'b0010;
    tx_len   = {N{16'd4}};
    tx_data  = {N{32'h000000AA}};
    tx_valid = 4'b1111;
    put_rdy  = 1'b1;
    @(posedge clk);
    #1;
    tx_req = '0;
    @(negedge clk);
    check("abort_hdr", put_data, 32'hA5010004);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("abort_pre_en", 32'(put_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_put_en",    32'(put_en),    32'd0);
    check("abort_put_data",  put_data,       32'd0);
    check("abort_tx_ready",  32'(tx_ready),  32'd0);
    check("abort_stat_msgs", 32'(stat_msgs), 32'd0);
    check("abort_stat_drop", 32'(stat_drop), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tx_req = 4'b0010;
    tx_len = {N{16'd1}};
    @(negedge clk);
    check("fresh_idle_en", 32'(put_en), 32'd0);
    @(posedge clk);
    #1;
    tx_req = '0;
    @(negedge clk);
    check("fresh_gnt",    32'(tx_gnt), 32'b0010);
    check("fresh_put_en", 32'(put_en), 32'd1);
    check("fresh_hdr",    put_data,    32'hA5010001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
